// File: rtl/onchip_frame_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : onchip_frame_reader_if
// Purpose  : Avalon-MM read bus plus Avalon-ST pixel-word stream bundle.
// Revision : 1.0
// ============================================================================
interface onchip_frame_reader_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_read;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;

    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;

    modport master (
        output avm_address, avm_chipselect, avm_read, avm_byteenable,
        input  avm_waitrequest, avm_readdata,
        output st_data, st_valid, st_sop, st_eop,
        input  st_ready
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_read, avm_byteenable,
        output avm_waitrequest, avm_readdata,
        input  st_data, st_valid, st_sop, st_eop,
        output st_ready
    );
endinterface
`default_nettype wire

// File: rtl/onchip_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : onchip_frame_reader
// Purpose  : Credit-limited Avalon-MM word reader feeding an Avalon-ST stream.
// Revision : 1.0
// ============================================================================
module onchip_frame_reader #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 16,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    base_address_i,
    input  logic [CNT_W-1:0]     word_count_i,
    output logic                 busy_o,
    output logic                 done_o,
    onchip_frame_reader_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int SUM_W = PTR_W + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    remaining_q;
    logic [CNT_W-1:0]    total_q;
    logic [CNT_W-1:0]    out_idx_q;
    logic [OCC_W-1:0]    inflight_q;
    logic [OCC_W-1:0]    fifo_cnt_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [READ_LATENCY-1:0] vld_q;
    logic                done_q;

    logic credit_ok;
    logic rd_req;
    logic rd_acc;
    logic ret;
    logic pop;
    logic st_valid;

    // Every word not yet handed downstream owns a FIFO slot, so returns never overflow.
    assign credit_ok = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < SUM_W'(FIFO_DEPTH);
    assign rd_acc    = rd_req & ~bus.avm_waitrequest;
    assign ret       = vld_q[READ_LATENCY-1];
    assign st_valid  = (fifo_cnt_q != '0);
    assign pop       = st_valid & bus.st_ready;

    always_comb begin
        state_d = state_q;
        rd_req  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (word_count_i == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_req = credit_ok;
                if (rd_acc && (remaining_q == CNT_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((inflight_q == '0) && (fifo_cnt_q == '0)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            total_q     <= '0;
            out_idx_q   <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_FIN);

            if ((state_q == S_IDLE) && start_i) begin
                addr_q      <= base_address_i;
                remaining_q <= word_count_i;
                total_q     <= word_count_i;
                out_idx_q   <= '0;
            end else begin
                if (rd_acc) begin
                    addr_q      <= addr_q + ADDR_W'(1);
                    remaining_q <= remaining_q - CNT_W'(1);
                end
                if (pop) begin
                    out_idx_q <= out_idx_q + CNT_W'(1);
                end
            end

            case ({rd_acc, ret})
                2'b10:   inflight_q <= inflight_q + OCC_W'(1);
                2'b01:   inflight_q <= inflight_q - OCC_W'(1);
                default: inflight_q <= inflight_q;
            endcase

            if (ret) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            case ({ret, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + OCC_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - OCC_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ret) begin
            fifo_mem_q[wr_ptr_q] <= bus.avm_readdata;
        end
    end

    // Clearing the return tracker on reset is what discards late readdata.
    generate
        if (READ_LATENCY == 1) begin : g_vld_single
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= rd_acc;
                end
            end
        end else begin : g_vld_chain
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= {vld_q[READ_LATENCY-2:0], rd_acc};
                end
            end
        end
    endgenerate

    assign bus.avm_address    = addr_q;
    assign bus.avm_read       = rd_req;
    assign bus.avm_chipselect = rd_req;
    assign bus.avm_byteenable = 4'hF;
    assign bus.st_data        = fifo_mem_q[rd_ptr_q];
    assign bus.st_valid       = st_valid;
    assign bus.st_sop         = st_valid && (out_idx_q == '0);
    assign bus.st_eop         = st_valid && (out_idx_q == (total_q - CNT_W'(1)));

    assign busy_o = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done_o = done_q;
endmodule
`default_nettype wire

// File: tb/tb_onchip_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_frame_reader
// Purpose  : Runs READ_LATENCY=1 and =3 readers side by side against a memory model.
// Revision : 1.0
// ============================================================================
module tb_onchip_frame_reader;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_in = '0;
    logic [CW-1:0] cnt_in = '0;
    logic          waitreq = 1'b0;
    logic          st_rdy = 1'b1;
    logic          busy0, busy1, done0, done1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    onchip_frame_reader_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
    onchip_frame_reader_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    assign if0.avm_waitrequest = waitreq;
    assign if1.avm_waitrequest = waitreq;
    assign if0.st_ready        = st_rdy;
    assign if1.st_ready        = st_rdy;

    onchip_frame_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .READ_LATENCY(1), .FIFO_DEPTH(8)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .start_i(start), .base_address_i(base_in),
        .word_count_i(cnt_in), .busy_o(busy0), .done_o(done0), .bus(if0)
    );
    onchip_frame_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .READ_LATENCY(3), .FIFO_DEPTH(8)) u_dut_l3 (
        .clk(clk), .reset_n(reset_n), .start_i(start), .base_address_i(base_in),
        .word_count_i(cnt_in), .busy_o(busy1), .done_o(done1), .bus(if1)
    );

    // Memory model: fixed-latency return pipelines, garbage when no word is due
    logic [DW-1:0] mem [32768];
    logic [3:0]    p_v0 = '0;
    logic [3:0]    p_v1 = '0;
    logic [AW-1:0] p_a0 [4];
    logic [AW-1:0] p_a1 [4];

    always @(posedge clk) begin
        p_v0 <= {p_v0[2:0], if0.avm_read & ~if0.avm_waitrequest};
        p_v1 <= {p_v1[2:0], if1.avm_read & ~if1.avm_waitrequest};
        p_a0[0] <= if0.avm_address;
        p_a1[0] <= if1.avm_address;
        for (int i = 1; i < 4; i++) begin
            p_a0[i] <= p_a0[i-1];
            p_a1[i] <= p_a1[i-1];
        end
    end
    assign if0.avm_readdata = p_v0[0] ? mem[p_a0[0]] : 32'hDEAD_BEEF;
    assign if1.avm_readdata = p_v1[2] ? mem[p_a1[2]] : 32'hDEAD_BEEF;

    // Observation logs, filled at the falling edge
    int            occ [2];
    int            n_acc [2];
    int            n_got [2];
    int            n_done [2];
    int            viol_credit [2];
    int            viol_stall [2];
    int            viol_hold [2];
    int            viol_cs [2];
    logic [AW-1:0] acc_a [2][512];
    logic [DW-1:0] got_d [2][512];
    logic          got_sop [2][512];
    logic          got_eop [2][512];
    bit            stall_v [2];
    logic [AW-1:0] stall_a [2];
    bit            hold_v [2];
    logic [DW+1:0] hold_p [2];

    task automatic mon(input int k, input logic rd, input logic wr, input logic [AW-1:0] addr,
                       input logic cs, input logic [3:0] be, input logic v, input logic r,
                       input logic [DW-1:0] d, input logic sop, input logic eop, input logic dn);
        if (!reset_n) begin
            occ[k]     = 0;
            stall_v[k] = 1'b0;
            hold_v[k]  = 1'b0;
            return;
        end
        if ((cs !== rd) || (be !== 4'hF)) viol_cs[k]++;
        if (stall_v[k] && ((rd !== 1'b1) || (addr !== stall_a[k]))) viol_stall[k]++;
        if (hold_v[k] && ((v !== 1'b1) || ({sop, eop, d} !== hold_p[k]))) viol_hold[k]++;
        if ((rd === 1'b1) && (occ[k] >= 8)) viol_credit[k]++;
        if (dn === 1'b1) n_done[k]++;
        if ((rd === 1'b1) && (wr === 1'b0)) begin
            acc_a[k][n_acc[k] % 512] = addr;
            n_acc[k]++;
            occ[k]++;
        end
        if ((v === 1'b1) && (r === 1'b1)) begin
            got_d[k][n_got[k] % 512]   = d;
            got_sop[k][n_got[k] % 512] = sop;
            got_eop[k][n_got[k] % 512] = eop;
            n_got[k]++;
            occ[k]--;
        end
        stall_v[k] = (rd === 1'b1) && (wr === 1'b1);
        stall_a[k] = addr;
        hold_v[k]  = (v === 1'b1) && (r === 1'b0);
        hold_p[k]  = {sop, eop, d};
    endtask

    always @(negedge clk) begin
        mon(0, if0.avm_read, if0.avm_waitrequest, if0.avm_address, if0.avm_chipselect, if0.avm_byteenable,
            if0.st_valid, if0.st_ready, if0.st_data, if0.st_sop, if0.st_eop, done0);
        mon(1, if1.avm_read, if1.avm_waitrequest, if1.avm_address, if1.avm_chipselect, if1.avm_byteenable,
            if1.st_valid, if1.st_ready, if1.st_data, if1.st_sop, if1.st_eop, done1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_xfer(input int k, input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                              input int sg, input int sa, input int sd);
        logic [AW-1:0] a;
        string         sfx;
        sfx = (k == 0) ? "L1" : "L3";
        chk({"words_out_", sfx}, 64'(n_got[k] - sg), 64'(cnt));
        chk({"reads_issued_", sfx}, 64'(n_acc[k] - sa), 64'(cnt));
        chk({"done_pulses_", sfx}, 64'(n_done[k] - sd), 64'd1);
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + AW'(i);
            chk($sformatf("addr[%0d]_%s", i, sfx), 64'(acc_a[k][(sa + i) % 512]), 64'(a));
            chk($sformatf("data[%0d]_%s", i, sfx), 64'(got_d[k][(sg + i) % 512]), 64'(mem[a]));
            chk($sformatf("sop[%0d]_%s", i, sfx), 64'(got_sop[k][(sg + i) % 512]), 64'(i == 0));
            chk($sformatf("eop[%0d]_%s", i, sfx), 64'(got_eop[k][(sg + i) % 512]), 64'(i == int'(cnt) - 1));
        end
    endtask

    task automatic run_xfer(input logic [AW-1:0] base, input logic [CW-1:0] cnt, input bit rnd_wait,
                            input int rhold, input bit rnd_ready, input int inject_at,
                            output int da0, output int da1, output int va0, output int va1,
                            output bit bz0, output bit bz1);
        int sg [2];
        int sa [2];
        int sd [2];
        int cyc;
        for (int k = 0; k < 2; k++) begin
            sg[k] = n_got[k];
            sa[k] = n_acc[k];
            sd[k] = n_done[k];
        end
        da0 = -1; da1 = -1; va0 = -1; va1 = -1; bz0 = 1'b0; bz1 = 1'b0;
        @(posedge clk); #1;
        start   = 1'b1;
        base_in = base;
        cnt_in  = cnt;
        waitreq = 1'b0;
        st_rdy  = (rhold > 0) ? 1'b0 : 1'b1;
        cyc     = 0;
        while (((da0 < 0) || (da1 < 0)) && (cyc < 3000)) begin
            @(posedge clk); #1;
            cyc++;
            start   = 1'b0;
            waitreq = rnd_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            st_rdy  = (cyc < rhold) ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            if (cyc == inject_at) begin
                start   = 1'b1;
                base_in = AW'($urandom);
                cnt_in  = CW'($urandom_range(1, 50));
            end
            if (cyc == 1) begin
                bz0 = busy0;
                bz1 = busy1;
            end
            if ((va0 < 0) && if0.st_valid) va0 = cyc;
            if ((va1 < 0) && if1.st_valid) va1 = cyc;
            if ((da0 < 0) && done0) da0 = cyc;
            if ((da1 < 0) && done1) da1 = cyc;
            if ((rhold > 0) && (cyc == rhold - 1)) begin
                chk("read_off_when_full_L1", 64'(if0.avm_read), 64'd0);
                chk("read_off_when_full_L3", 64'(if1.avm_read), 64'd0);
                chk("outstanding_full_L1", 64'(occ[0]), 64'd8);
                chk("outstanding_full_L3", 64'(occ[1]), 64'd8);
            end
        end
        chk("transfer_completed", 64'((da0 >= 0) && (da1 >= 0)), 64'd1);
        start   = 1'b0;
        waitreq = 1'b0;
        st_rdy  = 1'b1;
        @(negedge clk); #1;
        check_xfer(0, base, cnt, sg[0], sa[0], sd[0]);
        check_xfer(1, base, cnt, sg[1], sa[1], sd[1]);
        chk("busy_after_done_L1", 64'(busy0), 64'd0);
        chk("busy_after_done_L3", 64'(busy1), 64'd0);
    endtask

    initial begin
        int d0, d1, v0, v1, cyc;
        bit b0, b1;
        for (int i = 0; i < 32768; i++) mem[i] = $urandom;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_L1", 64'(busy0), 64'd0);
        chk("rst_done_L3", 64'(done1), 64'd0);
        chk("rst_read_L1", 64'(if0.avm_read), 64'd0);
        chk("rst_valid_L3", 64'(if1.st_valid), 64'd0);
        chk("rst_addr_L1", 64'(if0.avm_address), 64'd0);
        chk("rst_sopeop_L3", 64'({if1.st_sop, if1.st_eop}), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Basic run, first-word latency, busy
        run_xfer(15'h0010, 16'd4, 1'b0, 0, 1'b0, -1, d0, d1, v0, v1, b0, b1);
        chk("first_word_latency_L1", 64'(v0), 64'd3);
        chk("first_word_latency_L3", 64'(v1), 64'd5);
        chk("busy_after_start_L1", 64'(b0), 64'd1);
        chk("busy_after_start_L3", 64'(b1), 64'd1);

        // Downstream blocked for 30 cycles
        run_xfer(AW'($urandom), 16'd20, 1'b0, 30, 1'b0, -1, d0, d1, v0, v1, b0, b1);

        // Address wrap
        run_xfer(15'h7FFE, 16'd4, 1'b0, 0, 1'b0, -1, d0, d1, v0, v1, b0, b1);

        // Zero-length and single-word transfers
        run_xfer(15'h0123, 16'd0, 1'b0, 0, 1'b0, -1, d0, d1, v0, v1, b0, b1);
        chk("zero_len_done_time_L1", 64'(d0), 64'd2);
        chk("zero_len_done_time_L3", 64'(d1), 64'd2);
        chk("zero_len_no_valid_L1", 64'(v0), 64'hFFFF_FFFF_FFFF_FFFF);
        run_xfer(15'h0456, 16'd1, 1'b0, 0, 1'b0, -1, d0, d1, v0, v1, b0, b1);

        // Random stalls and backpressure with a stray start mid-transfer
        for (int t = 0; t < 3; t++) begin
            run_xfer(AW'($urandom), CW'($urandom_range(8, 40)), 1'b1, 0, 1'b1, 3, d0, d1, v0, v1, b0, b1);
        end

        // Reset with reads outstanding, then a short transfer
        @(posedge clk); #1;
        start   = 1'b1;
        base_in = AW'($urandom);
        cnt_in  = 16'd20;
        st_rdy  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while ((occ[1] < 5) && (cyc < 50)) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("outstanding_before_reset", 64'(occ[1] >= 5), 64'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy_L3", 64'(busy1), 64'd0);
        chk("midrst_read_L3", 64'(if1.avm_read), 64'd0);
        chk("midrst_valid_L3", 64'(if1.st_valid), 64'd0);
        chk("midrst_addr_L3", 64'(if1.avm_address), 64'd0);
        chk("midrst_sopeop_L3", 64'({if1.st_sop, if1.st_eop}), 64'd0);
        chk("midrst_valid_L1", 64'(if0.st_valid), 64'd0);
        chk("midrst_done_L1", 64'(done0), 64'd0);
        reset_n = 1'b1;
        st_rdy  = 1'b1;
        run_xfer(AW'($urandom), 16'd2, 1'b0, 0, 1'b0, -1, d0, d1, v0, v1, b0, b1);

        for (int k = 0; k < 2; k++) begin
            chk($sformatf("credit_violations_%0d", k), 64'(viol_credit[k]), 64'd0);
            chk($sformatf("stall_hold_violations_%0d", k), 64'(viol_stall[k]), 64'd0);
            chk($sformatf("stream_hold_violations_%0d", k), 64'(viol_hold[k]), 64'd0);
            chk($sformatf("cs_be_violations_%0d", k), 64'(viol_cs[k]), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/onchip_frame_reader.md
Name: onchip_frame_reader

Overview:
Avalon-MM read initiator that fetches a run of 32-bit words from the on-chip frame memory's s1/s2 slave port and emits them as an Avalon-ST pixel-word stream. It targets the single-port memory with fixed read latency and no waitrequest, but also honours waitrequest for fabric insertion. A small internal FIFO absorbs read latency. Credit-based issue means returned read data is never dropped, even under downstream backpressure.

Parameters:
ADDR_W, 15, word address width; matches the memory's 32768-word depth.
DATA_W, 32, data width.
CNT_W, 16, word_count width.
READ_LATENCY, 1, cycles from accepted read to readdata valid; legal range 1..4.
FIFO_DEPTH, 8, output FIFO entries; power of two, at least READ_LATENCY+1.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse that begins a transfer; ignored while busy=1
base_address  in  ADDR_W  first word address; sampled when start is accepted
word_count  in  CNT_W  number of words; sampled when start is accepted
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last word has been accepted downstream
avm_address  out  ADDR_W  word address
avm_chipselect  out  1  equal to avm_read
avm_read  out  1  read request
avm_byteenable  out  4  constant 4'hF
avm_waitrequest  in  1  stall; tie to 0 for direct memory connection
avm_readdata  in  DATA_W  read data, valid READ_LATENCY cycles after acceptance
st_data  out  DATA_W  stream data
st_valid  out  1  stream valid
st_ready  in  1  downstream ready
st_sop  out  1  high with the first word of a transfer
st_eop  out  1  high with the last word of a transfer

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; busy, done, avm_read, st_valid, st_sop and st_eop are 0.
  - avm_address=0; FIFO emptied; in-flight tracking cleared.
  - Reset mid-transfer abandons the transfer. Late readdata arriving after reset is discarded.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: start=1 latches base_address and word_count.
    - word_count=0 goes to FIN; no reads issued.
    - word_count>0 goes to ISSUE.
  - ISSUE: one read is issued per cycle when credits allow.
    - A read is accepted when avm_read=1 and avm_waitrequest=0.
    - avm_address and avm_read hold stable while waitrequest=1.
    - After the last read is accepted, go to DRAIN.
  - DRAIN: wait until all in-flight reads have returned and the FIFO is empty with the last word accepted, then go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, return to IDLE. start is accepted again on the next cycle.
- Credits:
  - avm_read may assert only when fifo_count + inflight < FIFO_DEPTH. Both counts use the values of the current cycle.
  - inflight increments on an accepted read and decrements on a returned word; both in the same cycle leaves it unchanged.
- Read return:
  - Word k is written to the FIFO exactly READ_LATENCY cycles after read k is accepted.
  - Implemented as a READ_LATENCY-deep valid shift register.
- Addressing: address increments by 1 per accepted read, modulo 2^ADDR_W, so 0x7FFF is followed by 0x0000.
- Stream output:
  - st_valid = FIFO not empty. st_data, st_sop and st_eop hold stable while st_valid=1 and st_ready=0.
  - st_sop is 1 on word index 0; st_eop is 1 on word index word_count-1. A single-word transfer has both set.
  - FIFO simultaneous read and write in one cycle is legal at every occupancy, including full and empty.
  - Write into an empty FIFO makes st_valid=1 on the next cycle (first-word latency from start is READ_LATENCY+2 cycles with st_ready=1).
- Throughput: with waitrequest=0 and st_ready=1 continuously, one word per cycle sustained.
- start while busy: ignored; no effect on the latched transfer.

Test Plan:
1. base=0x0010, count=4, READ_LATENCY=1, ready=1 -> reads 0x10..0x13 on consecutive cycles; st_data equals model memory; sop on word 0, eop on word 3; one done pulse.
2. count=20, st_ready=0 for 30 cycles then 1 -> fifo_count+inflight never exceeds 8; avm_read deasserts; no data lost; 20 words in order.
3. base=0x7FFE, count=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
4. count=0 -> no avm_read; done pulses 2 cycles after start; st_valid stays 0. count=1 -> single word with sop=eop=1.
5. Random avm_waitrequest 50%, READ_LATENCY=3, random st_ready -> address stable during stall; data matches memory; a start pulse injected mid-transfer is ignored.
6. reset_n=0 while 5 words are in flight -> next cycle all outputs are 0; a subsequent start with count=2 yields exactly 2 words.
